// File: rtl/pe_pkt_pkg.sv
// Shared PE packet definitions: type codes, header field widths and offsets.
// Used by both the packetizer and the depacketizer.
package pe_pkt_pkg;

  typedef enum logic [1:0] {
    SPIKE  = 2'b00,
    FILTER = 2'b01
  } pkt_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } depkt_state_e;

  localparam int TYPE_W = 2;
  localparam int DST_W  = 4;
  localparam int SRC_W  = 3;
  localparam int HDR_W  = TYPE_W + DST_W + SRC_W;
  localparam int STAT_W = 16;

  function automatic int payloadW(input int fw);
    return 3 * fw;
  endfunction

  function automatic int pktW(input int fw);
    return HDR_W + payloadW(fw);
  endfunction

  function automatic int typeLsb(input int fw);
    return pktW(fw) - TYPE_W;
  endfunction

  function automatic int dstLsb(input int fw);
    return typeLsb(fw) - DST_W;
  endfunction

  function automatic int srcLsb(input int fw);
    return dstLsb(fw) - SRC_W;
  endfunction

  function automatic int tsBit(input int fw);
    return fw;
  endfunction

  function automatic int osBit(input int fw);
    return fw + 1;
  endfunction

endpackage

// File: rtl/depkt_out_slot.sv
// One depacketizer output channel: a pending flag doubling as valid,
// plus a data register that holds steady until the transfer.
module depkt_out_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadData,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_depacketizer.sv
// Splits PE packets into timestep/residue/outspike or filter channels.
// Define DEPKT_STATS_EN to add saturating per-class packet counters.
module pe_depacketizer
  import pe_pkt_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int PKT_WIDTH    = 9 + 3 * FILTER_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PKT_WIDTH-1:0]      pkt_data,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  output logic                      ts_data,
  output logic                      ts_valid,
  input  logic                      ts_ready,
  output logic [FILTER_WIDTH-1:0]   res_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      os_data,
  output logic                      os_valid,
  input  logic                      os_ready,
  output logic [3*FILTER_WIDTH-1:0] flt_data,
  output logic                      flt_valid,
  input  logic                      flt_ready,
  output logic [2:0]                src_addr,
  output logic                      drop_pulse
`ifdef DEPKT_STATS_EN
  ,
  output logic [15:0]               spike_cnt,
  output logic [15:0]               flt_cnt,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int PAY_W = payloadW(FILTER_WIDTH);
  localparam int T_LSB = typeLsb(FILTER_WIDTH);
  localparam int D_LSB = dstLsb(FILTER_WIDTH);
  localparam int S_LSB = srcLsb(FILTER_WIDTH);
  localparam int TS_B  = tsBit(FILTER_WIDTH);
  localparam int OS_B  = osBit(FILTER_WIDTH);

  depkt_state_e state;

  logic [TYPE_W-1:0] pktType;
  logic [PAY_W-1:0]  payload;
  logic              isSpike;
  logic              isFilter;
  logic              accept;
  logic              loadSpike;
  logic              loadFlt;
  logic              allClear;
  logic              unusedDst;

  assign pktType  = pkt_data[T_LSB +: TYPE_W];
  assign payload  = pkt_data[PAY_W-1:0];
  assign isSpike  = (pktType == SPIKE);
  assign isFilter = (pktType == FILTER);

  // Routing already consumed dst; it is deliberately ignored here.
  assign unusedDst = ^pkt_data[D_LSB +: DST_W];

  assign pkt_ready = (state == IDLE) && !rst;
  assign accept    = pkt_valid && pkt_ready;
  assign loadSpike = accept && isSpike;
  assign loadFlt   = accept && isFilter;

  assign allClear = (!ts_valid  || ts_ready)
                 && (!res_valid || res_ready)
                 && (!os_valid  || os_ready)
                 && (!flt_valid || flt_ready);

  depkt_out_slot #(.W(1)) uTs (
    .clk(clk), .rst(rst),
    .load(loadSpike), .loadData(payload[TS_B]),
    .ready(ts_ready), .valid(ts_valid), .data(ts_data)
  );

  depkt_out_slot #(.W(FILTER_WIDTH)) uRes (
    .clk(clk), .rst(rst),
    .load(loadSpike), .loadData(payload[FILTER_WIDTH-1:0]),
    .ready(res_ready), .valid(res_valid), .data(res_data)
  );

  depkt_out_slot #(.W(1)) uOs (
    .clk(clk), .rst(rst),
    .load(loadSpike), .loadData(payload[OS_B]),
    .ready(os_ready), .valid(os_valid), .data(os_data)
  );

  depkt_out_slot #(.W(PAY_W)) uFlt (
    .clk(clk), .rst(rst),
    .load(loadFlt), .loadData(payload),
    .ready(flt_ready), .valid(flt_valid), .data(flt_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src_addr   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            src_addr <= pkt_data[S_LSB +: SRC_W];
            unique case (1'b1)
              isSpike:  state <= DRAIN;
              isFilter: state <= DRAIN;
              default:  drop_pulse <= 1'b1;
            endcase
          end
        end
        DRAIN: begin
          if (allClear) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEPKT_STATS_EN
  logic loadDrop;
  assign loadDrop = accept && !isSpike && !isFilter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_cnt <= '0;
      flt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (loadSpike && spike_cnt != 16'hFFFF) spike_cnt <= spike_cnt + 16'd1;
      if (loadFlt && flt_cnt != 16'hFFFF)     flt_cnt   <= flt_cnt + 16'd1;
      if (loadDrop && drop_cnt != 16'hFFFF)   drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_depacketizer.sv
// Bench for pe_depacketizer: directed packets plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_pe_depacketizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] pkt_data = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic        ts_data, ts_valid, ts_ready = 1'b1;
  logic [7:0]  res_data;
  logic        res_valid, res_ready = 1'b1;
  logic        os_data, os_valid, os_ready = 1'b1;
  logic [23:0] flt_data;
  logic        flt_valid, flt_ready = 1'b1;
  logic [2:0]  src_addr;
  logic        drop_pulse;
`ifdef DEPKT_STATS_EN
  logic [15:0] spike_cnt, flt_cnt, drop_cnt;
`endif

  pe_depacketizer #(.FILTER_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .os_data(os_data), .os_valid(os_valid), .os_ready(os_ready),
    .flt_data(flt_data), .flt_valid(flt_valid), .flt_ready(flt_ready),
    .src_addr(src_addr), .drop_pulse(drop_pulse)
`ifdef DEPKT_STATS_EN
    , .spike_cnt(spike_cnt), .flt_cnt(flt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: outstanding channels of the held packet, as a set.
  bit          mTsP, mResP, mOsP, mFltP;
  bit          mTs, mOs, mDrop, lastAccept;
  logic [7:0]  mRes;
  logic [23:0] mFlt;
  logic [2:0]  mSrc;
  int          mSpkCnt, mFltCnt, mDrpCnt;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nChecks++;
    if (a !== e) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic bit busy();
    return mTsP || mResP || mOsP || mFltP;
  endfunction

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic modelReset();
    {mTsP, mResP, mOsP, mFltP} = '0;
    mDrop = 0;
    lastAccept = 0;
    mSpkCnt = 0;
    mFltCnt = 0;
    mDrpCnt = 0;
  endtask

  task automatic modelStep();
    bit acc;
    acc = pkt_valid && !busy();
    lastAccept = acc;
    if (ts_ready)  mTsP  = 0;
    if (res_ready) mResP = 0;
    if (os_ready)  mOsP  = 0;
    if (flt_ready) mFltP = 0;
    mDrop = 0;
    if (acc) begin
      mSrc = pkt_data[26:24];
      case (pkt_data[32:31])
        2'd0: begin
          {mTsP, mResP, mOsP} = 3'b111;
          mRes = pkt_data[7:0];
          mTs  = pkt_data[8];
          mOs  = pkt_data[9];
          mSpkCnt = sat(mSpkCnt);
        end
        2'd1: begin
          mFltP = 1;
          mFlt  = pkt_data[23:0];
          mFltCnt = sat(mFltCnt);
        end
        default: begin
          mDrop = 1;
          mDrpCnt = sat(mDrpCnt);
        end
      endcase
    end
  endtask

  task automatic compareAll();
    chk("pkt_ready", pkt_ready, !busy());
    chk("ts_valid", ts_valid, mTsP);
    chk("res_valid", res_valid, mResP);
    chk("os_valid", os_valid, mOsP);
    chk("flt_valid", flt_valid, mFltP);
    chk("drop_pulse", drop_pulse, mDrop);
    if (mTsP)  chk("ts_data", ts_data, mTs);
    if (mResP) chk("res_data", res_data, mRes);
    if (mOsP)  chk("os_data", os_data, mOs);
    if (mFltP) chk("flt_data", flt_data, mFlt);
    if (busy()) chk("src_addr", src_addr, mSrc);
`ifdef DEPKT_STATS_EN
    chk("spike_cnt", spike_cnt, mSpkCnt);
    chk("flt_cnt", flt_cnt, mFltCnt);
    chk("drop_cnt", drop_cnt, mDrpCnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic allReady();
    {ts_ready, res_ready, os_ready, flt_ready} = 4'hF;
  endtask

  task automatic sendPkt(input logic [32:0] d);
    bit got;
    got = 0;
    pkt_data = d;
    pkt_valid = 1;
    allReady();
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = lastAccept;
    end
    pkt_valid = 0;
    chk("send_accept", got, 1);
    tick();
    tick();
  endtask

  logic [32:0] spk1, fltPkt, badPkt, spk2;

  initial begin
    spk1   = 33'h1D0001A5;
    fltPkt = {2'b01, 4'h0, 3'h2, 24'hC3B2A1};
    badPkt = {2'b11, 4'h3, 3'h1, 24'h00FFEE};
    spk2   = 33'h0B00036C;
    modelReset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_valids", {ts_valid, res_valid, os_valid, flt_valid}, 0);
    chk("rst_data", {ts_data, res_data, os_data, flt_data}, 0);
    chk("rst_src", src_addr, 0);
    chk("rst_drop", drop_pulse, 0);
    rst = 0;
    #1 chk("post_rst_ready", pkt_ready, 1);

    // Spike packet, all readies high
    @(negedge clk);
    pkt_data = spk1;
    pkt_valid = 1;
    tick();
    pkt_valid = 0;
    chk("model_res", mRes, 8'hA5);
    chk("spk_valids", {ts_valid, res_valid, os_valid, flt_valid}, 4'b1110);
    chk("spk_res", res_data, 8'hA5);
    chk("spk_ts", ts_data, 1);
    chk("spk_os", os_data, 0);
    chk("spk_src", src_addr, 3'h5);
    chk("spk_busy", pkt_ready, 0);
    tick();
    chk("spk_retired", {ts_valid, res_valid, os_valid}, 0);
    chk("spk_ready_back", pkt_ready, 1);

    // Spike with outspike stalled; a filter packet waits behind it
    pkt_data = spk1;
    pkt_valid = 1;
    os_ready = 0;
    tick();
    pkt_data = fltPkt;
    for (int k = 0; k < 5; k++) begin
      chk("stall_os_valid", os_valid, 1);
      chk("stall_os_data", os_data, 0);
      chk("stall_ready", pkt_ready, 0);
      chk("stall_flt", flt_valid, 0);
      if (k >= 1) chk("stall_ts_res", {ts_valid, res_valid}, 0);
      if (k == 4) os_ready = 1;
      tick();
    end
    chk("stall_os_done", os_valid, 0);
    chk("stall_ready_back", pkt_ready, 1);
    tick();
    pkt_valid = 0;
    chk("flt_valid", flt_valid, 1);
    chk("flt_data", flt_data, 24'hC3B2A1);
    chk("flt_src", src_addr, 3'h2);
    chk("flt_no_spike", {ts_valid, res_valid, os_valid}, 0);
    tick();
    chk("flt_retired", flt_valid, 0);

    // Invalid type is dropped
    pkt_data = badPkt;
    pkt_valid = 1;
    tick();
    pkt_valid = 0;
    chk("drop_pulse_hi", drop_pulse, 1);
    chk("drop_valids", {ts_valid, res_valid, os_valid, flt_valid}, 0);
    chk("drop_ready", pkt_ready, 1);
`ifdef DEPKT_STATS_EN
    chk("drop_cnt_one", drop_cnt, 1);
`endif
    tick();
    chk("drop_pulse_lo", drop_pulse, 0);

    // Asynchronous reset in the middle of a drain
    pkt_data = spk1;
    pkt_valid = 1;
    res_ready = 0;
    tick();
    pkt_valid = 0;
    chk("mid_res_valid", res_valid, 1);
    #2 rst = 1;
    #1;
    chk("arst_valids", {ts_valid, res_valid, os_valid, flt_valid}, 0);
    chk("arst_ready", pkt_ready, 0);
    chk("arst_res_data", res_data, 0);
    modelReset();
    #1 rst = 0;
    res_ready = 1;
    tick();
    chk("arst_ready_back", pkt_ready, 1);
    pkt_data = spk2;
    pkt_valid = 1;
    tick();
    pkt_valid = 0;
    chk("post_rst_res", res_data, 8'h6C);
    chk("post_rst_ts_os", {ts_data, os_data}, 2'b11);
    chk("post_rst_src", src_addr, 3'h3);
    tick();

`ifdef DEPKT_STATS_EN
    sendPkt(spk1);
    sendPkt(fltPkt);
    sendPkt(spk2);
    sendPkt(fltPkt);
    chk("stats_spike3", spike_cnt, 3);
    chk("stats_flt2", flt_cnt, 2);
`endif

    // Randomized traffic and backpressure
    for (int c = 0; c < 3000; c++) begin
      ts_ready  = ($urandom_range(0, 9) < 7);
      res_ready = ($urandom_range(0, 9) < 7);
      os_ready  = ($urandom_range(0, 9) < 7);
      flt_ready = ($urandom_range(0, 9) < 7);
      if (!(pkt_valid && !lastAccept)) begin
        pkt_valid = ($urandom_range(0, 99) < 60);
        pkt_data = {2'($urandom_range(0, 3)), 31'($urandom)};
      end
      tick();
    end
    pkt_valid = 0;
    allReady();
    tick();
    tick();

`ifdef DEPKT_STATS_EN
    force dut.spike_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.spike_cnt;
    mSpkCnt = 65535;
    sendPkt(spk1);
    chk("spike_cnt_sat", spike_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/pe_depacketizer.md
Name: pe_depacketizer

Overview:
- Receiving end of the PE packet format: accepts one packed packet of 9 + 3*FILTER_WIDTH bits and splits it into its field channels.
- Spike/residue packets fork into three independent output channels: timestep, residue, outspike.
- Filter packets go to one filter output channel. All other packet types are dropped.
- Clocked valid/ready block that sits between the NoC router ejection port and the PE input stage.

Parameters:
- FILTER_WIDTH, 8, width of one filter/residue word
- PKT_WIDTH, 9+3*FILTER_WIDTH, packet width (derived; do not override)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- pkt_data  in  PKT_WIDTH  incoming packet
- pkt_valid  in  1  packet valid
- pkt_ready  out  1  depacketizer can accept
- ts_data  out  1  timestep bit
- ts_valid / ts_ready  out / in  1  timestep channel handshake
- res_data  out  FILTER_WIDTH  residue word
- res_valid / res_ready  out / in  1  residue channel handshake
- os_data  out  1  outspike bit
- os_valid / os_ready  out / in  1  outspike channel handshake
- flt_data  out  3*FILTER_WIDTH  filter payload
- flt_valid / flt_ready  out / in  1  filter channel handshake
- src_addr  out  3  source field of the held packet; stable while any output is valid
- drop_pulse  out  1  one-cycle pulse when a packet is dropped

Behaviour:
- Packet layout, MSB first:
  - type[PKT_WIDTH-1:PKT_WIDTH-2]
  - dst[PKT_WIDTH-3:PKT_WIDTH-6]
  - src[PKT_WIDTH-7:PKT_WIDTH-9]
  - payload[3*FILTER_WIDTH-1:0]
- Types: SPIKE=2'b00, FILTER=2'b01; 2'b10 and 2'b11 are invalid.
- SPIKE payload fields: residue=payload[FILTER_WIDTH-1:0], timestep=payload[FILTER_WIDTH], outspike=payload[FILTER_WIDTH+1]. Upper payload bits are ignored.
- Handshakes: a transfer occurs on the rising clk edge where valid&&ready. Once asserted, valid holds until the transfer and data is stable throughout. An output's valid never depends combinationally on its ready.
- The dst field is not checked; routing already resolved it.
- FSM IDLE:
  - pkt_ready=1.
  - On pkt transfer, register payload and src and decode type.
  - SPIKE: set pending for ts, res, os -> DRAIN.
  - FILTER: set pending for flt -> DRAIN.
  - Invalid type: drop_pulse=1 next cycle, stay IDLE.
- FSM DRAIN:
  - pkt_ready=0. Each output valid = its pending bit.
  - A pending bit clears on its own transfer. The three SPIKE outputs complete in any order or simultaneously.
  - When all pending bits are clear at a clock edge -> IDLE.
- Latency: outputs are valid the cycle after packet acceptance.
- Throughput: at most one packet per 2 cycles, since there is no same-cycle bypass from DRAIN to accept.
- Reset, asynchronous, may arrive mid-DRAIN: state=IDLE, all pending=0, all *_valid=0, pkt_ready=0 while rst is high and 1 the first cycle after deassertion. All data outputs=0, src_addr=0, drop_pulse=0. A partially drained packet is discarded.

Optional Feature:
- DEPKT_STATS_EN defined: adds outputs spike_cnt[15:0], flt_cnt[15:0] and drop_cnt[15:0].
  - Each counter increments on acceptance of its packet class.
  - Counters saturate at 16'hFFFF and reset to 0.
- DEPKT_STATS_EN undefined: no counters or ports; behaviour otherwise identical.

Decomposition:
- Package pe_pkt_pkg holds:
  - pkt_type_e enum (SPIKE, FILTER)
  - field offset/width localparams as functions of FILTER_WIDTH
  - depkt_state_e (IDLE, DRAIN)
- The packetizer side reuses the same package.
- One sub-module, depkt_out_slot #(W): a pending flag plus data register with a valid/ready output, instantiated four times.

Test Plan (FILTER_WIDTH=8, PKT_WIDTH=33):
- SPIKE packet 33'h1D0001A5, all readies=1 -> next cycle ts/res/os valid with res=8'hA5, ts=1, os=0, src=3'h5. All retire one cycle later; pkt_ready=1 the cycle after that.
- Same packet with os_ready held 0 for 5 cycles -> ts and res retire after 1 cycle; os_valid holds 5 cycles with os=0 stable; pkt_ready=0 throughout, and a second packet held valid is not accepted until os retires.
- FILTER packet {2'b01,4'h0,3'h2,24'hC3B2A1} -> flt_data=24'hC3B2A1, flt_valid only; ts/res/os valid stay 0.
- Invalid-type packet with type=2'b11 -> drop_pulse high exactly one cycle; no output valid; pkt_ready stays 1. With DEPKT_STATS_EN, drop_cnt=1.
- rst asserted mid-DRAIN while res_valid=1 -> all valids fall with no clock edge needed; after deassertion a new SPIKE packet decodes correctly.
- DEPKT_STATS_EN: 3 SPIKE + 2 FILTER packets -> spike_cnt=3, flt_cnt=2. Force spike_cnt to 16'hFFFF, send another SPIKE packet -> spike_cnt stays 16'hFFFF.
